seven_seg_scan_controller: RTL and testbench
============================================

// Module: seven_seg_scan_controller
// PURPOSE
//   Sequencer for a multiplexed common-cathode 7-segment display. Accepts a binary value via
//   valid/ready, converts it to BCD sequentially, and scans DIGITS digits with brightness PWM.
//   It also applies leading-zero blanking. Sits between system logic and the display pins.
// PARAMETERS
//   SEL_BITS       2   log2 of digit count; DIGITS = 1<<SEL_BITS
//   BIN_WIDTH      14  width of load_value (unsigned)
//   SCAN_DIV_BITS  16  prescaler width; one digit slot = 2^SCAN_DIV_BITS clk cycles
//   BRIGHT_BITS    4   brightness resolution; must be <= SCAN_DIV_BITS
// PORTS
//   clk           in   1                  system clock, all logic on posedge
//   rst           in   1                  asynchronous reset, active-high
//   load_valid    in   1                  new value offered
//   load_ready    out  1                  controller idle, can accept
//   load_value    in   BIN_WIDTH          binary value to display
//   load_points   in   DIGITS             decimal points per digit, 1 = lit, bit i -> digit i
//   blank_lz      in   1                  1 = blank leading zeros (sampled on accept)
//   brightness    in   BRIGHT_BITS        PWM duty, sampled continuously
//   segments      out  8                  [6:0] GFEDCBA active-high; [7] DP active-low
//   sel           out  SEL_BITS           current digit index, 0 = least significant
//   digit_en      out  1                  active-high drive enable for digit sel
//   ovf           out  1                  last committed value exceeded 10^DIGITS-1
//   busy          out  1                  conversion in progress
// BEHAVIOUR
//   Reset: segments=8'h80, sel=0, digit_en=0, load_ready=1, busy=0, ovf=0, prescaler=0,
//     display digits=0, points=0, blank flag=0. Reset mid-conversion aborts it; nothing committed.
//   FSM IDLE -> CONV -> COMMIT -> IDLE.
//     IDLE: load_ready=1. On load_valid&&load_ready latch value/points/blank_lz, go CONV.
//     CONV: busy=1, load_ready=0; double-dabble, one bit per cycle, exactly BIN_WIDTH cycles.
//     COMMIT: one cycle; write BCD digits, points, blank flag, ovf into display regs; go IDLE.
//     Accept-to-commit latency = BIN_WIDTH+1 cycles. load_ready back high cycle after COMMIT.
//   Overflow: if value > 10^DIGITS-1, ovf=1 and every digit shows code 'E' (7'b1111001).
//     Blanking is not applied on overflow.
//   Segment table (hex 0-F, GFEDCBA): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//   Blanking: with blank flag set, digits above the most significant nonzero digit drive
//     segments[6:0]=0. Digit 0 is never blanked, so value 0 shows "0". DP unaffected by blanking.
//   Scan: free-running prescaler increments every cycle and wraps at 2^SCAN_DIV_BITS-1 -> 0.
//     On wrap: sel <= sel+1, wrapping DIGITS-1 -> 0. In the same cycle, segments reload from
//     display regs for the new sel. segments, sel, digit_en are registered; no glitches.
//   PWM: digit_en = (prescaler[SCAN_DIV_BITS-1 -: BRIGHT_BITS] < brightness).
//     brightness=0 keeps digit_en low always; max gives (2^BRIGHT_BITS-1)/2^BRIGHT_BITS duty.
//   Simultaneous COMMIT and prescaler wrap: the reload samples pre-commit (old) regs.
//     The new value appears at the next slot boundary. No partial-digit updates, ever.
//   load_value is ignored while load_ready=0. Back-to-back loads are legal; each is
//     committed in order.
// STRUCTURE
//   Package seven_seg_pkg: FSM state enum, 16-entry segment table constant, SEG_BLANK,
//     SEG_E, DP_OFF constants.
//   Sub-module bin2bcd_seq: start/done handshake, iterative double-dabble,
//     BIN_WIDTH-bit in, 4*DIGITS-bit BCD plus ovf out.
//   Top: FSM, display regs, prescaler, scan/PWM output regs.
// TESTING
//   1. Assert rst mid-scan -> outputs take reset values at once (async); after release, sel=0
//      and digit_en=0 until first compare.
//   2. Load 1234, DIGITS=4, blank_lz=0 -> load_ready low 15 cycles. Digits 0..3 show
//      66,4F,5B,06; DP bits high.
//   3. Load 7, blank_lz=1, points=4'b0010 -> digit0=07, digit1 segs=00 with DP bit low
//      (lit), digits2-3 = 00 with DP high.
//   4. Load 12000 (>9999) -> ovf=1; all digits show 79.
//   5. brightness=0 -> digit_en never high over 2 full scans. brightness=8, BRIGHT_BITS=4
//      -> digit_en high exactly half of every slot.
//   6. Time COMMIT on a prescaler-wrap cycle -> old value shown for that slot, new from next;
//      sel wraps 3->0 correctly.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared types and constants for the 7-segment scan controller.
//               Holds the controller FSM state type, the hex-to-segment glyph
//               table (GFEDCBA, active-high), blank/'E' glyphs, the inactive
//               decimal-point level and a small glyph lookup helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Glyph for hex value n sits in bits [7n+6:7n]; entry 0 at the LSBs.
    localparam logic [16*7-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic       DP_OFF    = 1'b1;    // decimal point pin is active-low

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[{3'b000, nibble} * 7'd7 +: 7];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative double-dabble binary-to-BCD converter, one input
//               bit per clock. The MSB is consumed on the start cycle itself,
//               so a conversion occupies exactly BIN_WIDTH clock edges.
//   clk    in   clock, posedge
//   rst    in   asynchronous reset, active-high
//   start  in   one-cycle pulse; samples bin and begins a conversion
//   bin    in   BIN_WIDTH-bit unsigned value
//   done   out  one-cycle pulse; bcd/ovf valid from this cycle until next start
//   bcd    out  DIGITS BCD digits, digit 0 in bits [3:0]
//   ovf    out  value did not fit in DIGITS decimal digits
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int c_CNT_W = $clog2(BIN_WIDTH + 1);

    logic [BIN_WIDTH-1:0] r_sr;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_run;
    logic                 r_done;
    logic                 r_ovf;
    logic [4*DIGITS-1:0]  w_adj;

    // Add-3 correction on every nibble that is 5 or more before the shift.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3)
                                                           : r_bcd[4*i +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                // BCD is all zero here, so the first step needs no correction.
                r_sr  <= bin << 1;
                r_bcd <= {{(4*DIGITS-1){1'b0}}, bin[BIN_WIDTH-1]};
                r_cnt <= c_CNT_W'(BIN_WIDTH - 1);
                r_run <= 1'b1;
                r_ovf <= 1'b0;
            end else if (r_run) begin
                r_bcd <= {w_adj[4*DIGITS-2:0], r_sr[BIN_WIDTH-1]};
                r_sr  <= r_sr << 1;
                r_cnt <= r_cnt - 1'b1;
                // A one leaving the top nibble belongs to a digit we do not
                // have, which happens exactly when the value is >= 10^DIGITS.
                r_ovf <= r_ovf | w_adj[4*DIGITS-1];
                if (r_cnt == c_CNT_W'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_controller
// Description : Multiplexed common-cathode 7-segment display sequencer.
//               Accepts a binary value over valid/ready, converts it to BCD,
//               commits it atomically into display registers, and scans the
//               digits with a free-running prescaler and brightness PWM.
//   clk          in   clock, posedge
//   rst          in   asynchronous reset, active-high
//   load_valid   in   new value offered
//   load_ready   out  controller idle, can accept
//   load_value   in   binary value to display
//   load_points  in   decimal points per digit (1 = lit)
//   blank_lz     in   blank leading zeros, sampled on accept
//   brightness   in   PWM duty, sampled continuously
//   segments     out  [6:0] GFEDCBA active-high, [7] DP active-low
//   sel          out  current digit index, 0 = least significant
//   digit_en     out  drive enable for digit sel
//   ovf          out  last committed value exceeded 10^DIGITS-1
//   busy         out  conversion in progress
// BRIGHT_BITS must not exceed SCAN_DIV_BITS.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int SEL_BITS      = 2,
    parameter int BIN_WIDTH     = 14,
    parameter int SCAN_DIV_BITS = 16,
    parameter int BRIGHT_BITS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [BIN_WIDTH-1:0]       load_value,
    input  logic [(1<<SEL_BITS)-1:0]   load_points,
    input  logic                       blank_lz,
    input  logic [BRIGHT_BITS-1:0]     brightness,
    output logic [7:0]                 segments,
    output logic [SEL_BITS-1:0]        sel,
    output logic                       digit_en,
    output logic                       ovf,
    output logic                       busy
);

    localparam int c_DIGITS = 1 << SEL_BITS;

    // Control FSM and display registers
    state_t                    r_state;
    logic                      r_load_ready;
    logic                      r_busy;
    logic [c_DIGITS-1:0]       r_pend_points;
    logic                      r_pend_blank;
    logic [4*c_DIGITS-1:0]     r_disp_digits;
    logic [c_DIGITS-1:0]       r_disp_points;
    logic                      r_disp_blank;
    logic                      r_disp_ovf;

    // Scan / PWM
    logic [SCAN_DIV_BITS-1:0]  r_presc;
    logic [SEL_BITS-1:0]       r_sel;
    logic [7:0]                r_segments;
    logic                      r_digit_en;

    logic                      w_accept;
    logic                      w_conv_done;
    logic [4*c_DIGITS-1:0]     w_bcd;
    logic                      w_bcd_ovf;
    logic [SCAN_DIV_BITS-1:0]  w_presc_next;
    logic                      w_wrap;
    logic [SEL_BITS-1:0]       w_sel_next;
    logic [4*c_DIGITS-1:0]     w_upper;
    logic                      w_blanked;
    logic                      w_dp;
    logic [6:0]                w_glyph;
    logic [7:0]                w_seg_next;

    // Ready is only high in IDLE, so this is also the IDLE accept condition.
    assign w_accept = load_valid && r_load_ready;

    bin2bcd_seq #(
        .BIN_WIDTH (BIN_WIDTH),
        .DIGITS    (c_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .bin   (load_value),
        .done  (w_conv_done),
        .bcd   (w_bcd),
        .ovf   (w_bcd_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_load_ready  <= 1'b1;
            r_busy        <= 1'b0;
            r_pend_points <= '0;
            r_pend_blank  <= 1'b0;
            r_disp_digits <= '0;
            r_disp_points <= '0;
            r_disp_blank  <= 1'b0;
            r_disp_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pend_points <= load_points;
                        r_pend_blank  <= blank_lz;
                        r_load_ready  <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (w_conv_done) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_disp_digits <= w_bcd;
                    r_disp_points <= r_pend_points;
                    r_disp_blank  <= r_pend_blank;
                    r_disp_ovf    <= w_bcd_ovf;
                    r_load_ready  <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_load_ready <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Glyph for the digit that becomes active at the next slot boundary.
    // It reads the display registers as they are before any same-edge
    // commit, so a digit never shows a mix of old and new values.
    assign w_presc_next = r_presc + 1'b1;
    assign w_wrap       = &r_presc;
    assign w_sel_next   = r_sel + 1'b1;
    assign w_upper      = r_disp_digits >> {w_sel_next, 2'b00};
    assign w_blanked    = r_disp_blank && (w_sel_next != '0) && (w_upper == '0);
    assign w_dp         = r_disp_points[w_sel_next] ? ~DP_OFF : DP_OFF;

    always_comb begin
        w_glyph = seg_decode(w_upper[3:0]);
        if (r_disp_ovf) begin
            w_glyph = SEG_E;
        end else if (w_blanked) begin
            w_glyph = SEG_BLANK;
        end
    end

    assign w_seg_next = {w_dp, w_glyph};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_sel      <= '0;
            r_segments <= {DP_OFF, SEG_BLANK};
            r_digit_en <= 1'b0;
        end else begin
            r_presc <= w_presc_next;
            // Computed from the upcoming prescaler value so the registered
            // enable lines up with the prescaler phase it describes.
            r_digit_en <= (w_presc_next[SCAN_DIV_BITS-1 -: BRIGHT_BITS] < brightness);
            if (w_wrap) begin
                r_sel      <= w_sel_next;
                r_segments <= w_seg_next;
            end
        end
    end

    assign load_ready = r_load_ready;
    assign busy       = r_busy;
    assign ovf        = r_disp_ovf;
    assign segments   = r_segments;
    assign sel        = r_sel;
    assign digit_en   = r_digit_en;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_controller
// Description : Self-checking bench for seven_seg_scan_controller with a
//               short prescaler (64-cycle digit slots). Expected displays are
//               produced by a behavioural model and queued when a load is
//               driven; a monitor pops them as each commit appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_controller;

    localparam int SEL_BITS      = 2;
    localparam int BIN_WIDTH     = 14;
    localparam int SCAN_DIV_BITS = 6;
    localparam int BRIGHT_BITS   = 4;
    localparam int SLOT          = 1 << SCAN_DIV_BITS;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   load_valid = 1'b0;
    logic                   load_ready;
    logic [BIN_WIDTH-1:0]   load_value = '0;
    logic [3:0]             load_points = '0;
    logic                   blank_lz = 1'b0;
    logic [BRIGHT_BITS-1:0] brightness = 4'd15;
    logic [7:0]             segments;
    logic [SEL_BITS-1:0]    sel;
    logic                   digit_en;
    logic                   ovf;
    logic                   busy;

    seven_seg_scan_controller #(
        .SEL_BITS      (SEL_BITS),
        .BIN_WIDTH     (BIN_WIDTH),
        .SCAN_DIV_BITS (SCAN_DIV_BITS),
        .BRIGHT_BITS   (BRIGHT_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .load_points (load_points),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .segments    (segments),
        .sel         (sel),
        .digit_en    (digit_en),
        .ovf         (ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] segs;   // byte i = segments expected for digit i
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    function automatic exp_t model(input int v, input logic [3:0] pts, input logic blk);
        exp_t       e;
        int         d[4];
        int         t;
        int         msd;
        logic [6:0] g;
        t   = v;
        msd = 0;
        e.ovf = (v > 9999);
        for (int i = 0; i < 4; i++) begin
            d[i] = t % 10;
            t    = t / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (e.ovf)                 g = 7'h79;
            else if (blk && i > msd)   g = 7'h00;
            else                       g = tbl[d[i]];
            e.segs[8*i +: 8] = {~pts[i], g};
        end
        return e;
    endfunction

    // Commit monitor: each rising load_ready pops one expected entry.
    logic prev_ready = 1'b1;
    int   low_cnt    = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_ready = 1'b1;
            low_cnt    = 0;
        end else begin
            if (!load_ready) begin
                low_cnt++;
            end else if (!prev_ready) begin
                if (exp_q.size() == 0) begin
                    timeout("sb_unexpected_commit");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("commit_ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
                    chk("ready_low_cycles", low_cnt, 15);
                end
                low_cnt = 0;
            end
            prev_ready = load_ready;
        end
    end

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!load_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!load_ready) timeout(tag);
    endtask

    task automatic wait_sel_change(input string tag);
        logic [1:0] p;
        int         k;
        p = sel;
        k = 0;
        while (sel == p && k < 2*SLOT) begin
            @(negedge clk);
            k++;
        end
        if (sel == p) timeout(tag);
    endtask

    task automatic do_load(input int v, input logic [3:0] pts, input logic blk, output exp_t e);
        wait_ready("load_wait_ready");
        load_value  = BIN_WIDTH'(v);
        load_points = pts;
        blank_lz    = blk;
        load_valid  = 1'b1;
        e = model(v, pts, blk);
        exp_q.push_back(e);
        @(negedge clk);
        load_valid  = 1'b0;
        // Scramble the inputs: they must have been latched on accept.
        load_value  = BIN_WIDTH'($urandom);
        load_points = ~pts;
        blank_lz    = ~blk;
        chk("accept_ready_busy", {30'd0, load_ready, busy}, 32'b01);
    endtask

    task automatic check_scan(input exp_t e, input string tag);
        logic [1:0] prev;
        logic [1:0] nxt;
        for (int n = 0; n < 4; n++) begin
            prev = sel;
            nxt  = prev + 2'd1;
            wait_sel_change({tag, "_slot"});
            chk({tag, "_sel"}, {30'd0, sel}, {30'd0, nxt});
            chk($sformatf("%s_digit%0d", tag, sel), {24'd0, segments}, {24'd0, e.segs[8*sel +: 8]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=time limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e1, e2, e3, e4, ea, eb, e5, e6;
        logic [1:0] nxt;
        int cnt;

        // 1. Reset values, async reset mid-scan
        repeat (3) @(negedge clk);
        chk("rst_segments", {24'd0, segments}, 32'h80);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_digit_en", {31'd0, digit_en}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_sel", {30'd0, sel}, 32'd0);
        chk("post_rst_en", {31'd0, digit_en}, 32'd0);
        @(negedge clk);
        repeat (99) @(negedge clk);
        chk("pre_rst_sel", {30'd0, sel}, 32'd1);
        chk("pre_rst_en", {31'd0, digit_en}, 32'd1);
        chk("pre_rst_seg", {24'd0, segments}, 32'hBF);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_seg", {24'd0, segments}, 32'h80);
        chk("async_rst_sel", {30'd0, sel}, 32'd0);
        chk("async_rst_en", {31'd0, digit_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_sel", {30'd0, sel}, 32'd0);
        chk("rel_en", {31'd0, digit_en}, 32'd0);
        repeat (20) @(negedge clk);
        chk("rel_sel_hold", {30'd0, sel}, 32'd0);

        // 2. Plain value, no blanking
        do_load(1234, 4'b0000, 1'b0, e1);
        wait_ready("t2_commit");
        check_scan(e1, "v1234");

        // 3. Leading-zero blanking with a decimal point on a blanked digit
        do_load(7, 4'b0010, 1'b1, e2);
        wait_ready("t3_commit");
        check_scan(e2, "v7");

        // 4. Overflow
        do_load(12000, 4'b0000, 1'b0, e3);
        wait_ready("t4_commit");
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        check_scan(e3, "v12000");

        // Back-to-back loads: first just over the limit, second zero with blanking
        wait_ready("b2b_wait");
        load_value  = BIN_WIDTH'(10000);
        load_points = 4'b0000;
        blank_lz    = 1'b0;
        load_valid  = 1'b1;
        ea = model(10000, 4'b0000, 1'b0);
        exp_q.push_back(ea);
        @(negedge clk);
        load_value  = BIN_WIDTH'(0);
        blank_lz    = 1'b1;
        eb = model(0, 4'b0000, 1'b1);
        exp_q.push_back(eb);
        wait_ready("b2b_first");
        @(negedge clk);
        load_valid = 1'b0;
        wait_ready("b2b_second");
        check_scan(eb, "v0");

        // Interior zeros stay lit under blanking
        do_load(1000, 4'b1000, 1'b1, e4);
        wait_ready("v1000_commit");
        check_scan(e4, "v1000");

        // 5. PWM
        brightness = 4'd0;
        cnt = 0;
        repeat (8*SLOT) begin
            @(negedge clk);
            cnt += int'(digit_en);
        end
        chk("pwm_b0_high", cnt, 0);
        brightness = 4'd8;
        wait_sel_change("pwm_align");
        for (int s = 0; s < 4; s++) begin
            wait_sel_change("pwm_b8_slot");
            cnt = int'(digit_en);
            repeat (SLOT - 1) begin
                @(negedge clk);
                cnt += int'(digit_en);
            end
            chk($sformatf("pwm_b8_slot%0d", s), cnt, SLOT / 2);
        end
        brightness = 4'd15;
        wait_sel_change("pwm_b15_align");
        wait_sel_change("pwm_b15_slot");
        cnt = int'(digit_en);
        repeat (SLOT - 1) begin
            @(negedge clk);
            cnt += int'(digit_en);
        end
        chk("pwm_b15_slot", cnt, (SLOT * 15) / 16);

        // 6. Commit lands on a prescaler-wrap edge
        wait_sel_change("t6_align");
        repeat (48) @(negedge clk);
        load_value  = BIN_WIDTH'(42);
        load_points = 4'b0001;
        blank_lz    = 1'b1;
        load_valid  = 1'b1;
        e6 = model(42, 4'b0001, 1'b1);
        exp_q.push_back(e6);
        @(negedge clk);
        load_valid = 1'b0;
        nxt = sel + 2'd1;
        wait_sel_change("t6_wrap");
        chk("t6_commit_on_wrap", {31'd0, load_ready}, 32'd1);
        chk("t6_sel", {30'd0, sel}, {30'd0, nxt});
        chk("t6_old_value", {24'd0, segments}, {24'd0, e4.segs[8*sel +: 8]});
        nxt = sel + 2'd1;
        wait_sel_change("t6_next");
        chk("t6_sel_next", {30'd0, sel}, {30'd0, nxt});
        chk("t6_new_value", {24'd0, segments}, {24'd0, e6.segs[8*sel +: 8]});
        check_scan(e6, "v42");

        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
